lsu: RTL
========

# lsu

Load/store unit that turns pipeline load/store requests into accesses on the data-memory port. It drives `wr_en`, `bit_wr_en`, `addr` and `wr_data`, and consumes the combinational `rd_data`. It generates byte-lane masks, splits accesses that cross a word boundary into two word accesses, and merges and sign- or zero-extends load data. It sits between the execute stage and `dmem`, with a valid/ready handshake on each side toward the pipeline.

## Interface
- `DMEM_SIZE`, default `rv32_pkg::DMEM_SIZE`: data memory size in bytes (multiple of 4).
- `clk  in  1`: clock, rising edge.
- `rst_n  in  1`: synchronous, active-low reset.
- `req_valid  in  1`: request present.
- `req_ready  out  1`: LSU can accept; high only in IDLE.
- `req_store  in  1`: 1 = store, 0 = load.
- `req_funct3  in  3`: RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr  in  32`: byte address.
- `req_wdata  in  32`: store data, right-aligned.
- `resp_valid  out  1`: completion present.
- `resp_ready  in  1`: pipeline accepts completion.
- `resp_rdata  out  32`: extended load data; 0 for stores and errors.
- `resp_err  out  1`: misaddressed or illegal funct3.
- `dmem_wr_en  out  1`: write strobe.
- `dmem_bit_wr_en  out  32`: per-bit write mask.
- `dmem_addr  out  32`: word-aligned byte address.
- `dmem_wr_data  out  32`: lane-shifted write data.
- `dmem_rd_data  in  32`: combinational read data.

## Operation
- States: IDLE, ACC0, ACC1, RESP.
  - IDLE → ACC0 on `req_valid && req_ready`. Request fields are registered at this point.
  - ACC0 → ACC1 if the access crosses a word; otherwise ACC0 → RESP.
  - ACC1 → RESP.
  - RESP → IDLE when `resp_ready`.
- Size `sz` = 1/2/4 bytes from funct3[1:0]. Offset `off` = addr[1:0]. An access crosses a word when `off + sz > 4`.
- Lane mask `m` = byte mask of `sz` low bytes, expanded to bits.
- ACC0 drives:
  - `dmem_addr = addr & ~3`
  - `dmem_bit_wr_en = m << 8*off` (truncated to 32 bits)
  - `dmem_wr_data = wdata << 8*off`
- ACC1 drives:
  - `dmem_addr = (addr & ~3) + 4`
  - `dmem_bit_wr_en = m >> 8*(4-off)`
  - `dmem_wr_data = wdata >> 8*(4-off)`
- `dmem_wr_en = req_store` in ACC0 and ACC1, and 0 in every other state.
- Loads:
  - `dmem_rd_data` is captured into lo at the end of ACC0 and into hi at the end of ACC1 (hi = 0 if ACC1 is not entered).
  - Result = `{hi,lo} >> 8*off`, low `sz` bytes.
  - Sign-extend when funct3[2] = 0; zero-extend otherwise. LW ignores funct3[2].
- Errors:
  - Conditions: `addr + sz > DMEM_SIZE` (compute 33-bit, no wrap), illegal load funct3 (3'b011, 3'b110, 3'b111), or store funct3 > 3'b010.
  - ACC0 issues no write (`dmem_wr_en = 0`) and goes to RESP.
  - Response is `resp_err = 1`, `resp_rdata = 0`.
- `dmem_addr` and masks are 0 when not in ACC0/ACC1.

## Timing
- Request accepted on edge N:
  - ACC0 is cycle N+1.
  - Non-crossing access: `resp_valid` rises in cycle N+2.
  - Crossing access: ACC1 is N+2 and `resp_valid` rises in N+3.
- Store writes land on the clock edge ending ACC0 and on the edge ending ACC1.
- `resp_valid` stays high with stable `resp_rdata` and `resp_err` until `resp_ready`.
- `req_ready` returns high the cycle after the response handshake. There is no back-to-back overlap (one outstanding request).
- Reset: every register clears; state = IDLE.
  - Reset values: `req_ready` 1, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0.
  - All dmem outputs are 0.
- Reset asserted during ACC0 or ACC1: `dmem_wr_en` is 0 in that cycle, so no write is committed on that edge. A split store may be left half-written; that is acceptable and not recovered.
- A request is not sampled while `rst_n` = 0.

## Structure
- `rv32_pkg` holds:
  - `DMEM_SIZE`;
  - funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the `lsu_state_e` enum.
- One sub-module, `lsu_align`: combinational lane-shift, mask generation and load extraction/extension, shared by both access phases. The FSM and registers live in `lsu`.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10 → write mask 0xFFFFFFFF at `dmem_addr` 0x10; `resp_rdata` 0xDEADBEEF at N+2.
- SB 0x5A to 0x13 → `dmem_bit_wr_en` 0xFF000000, `dmem_wr_data[31:24]` = 0x5A. Then LB 0x13 → 0x0000005A. Writing 0x80 and loading gives LB → 0xFFFFFF80 and LBU → 0x00000080.
- SW 0x11223344 to 0x21 (crossing):
  - ACC0 at 0x20 with mask 0xFFFFFF00 and data 0x22334400;
  - ACC1 at 0x24 with mask 0x000000FF and data 0x00000011;
  - LW 0x21 returns 0x11223344 at N+3.
- LH at `DMEM_SIZE-1` → no write anywhere, `resp_err` 1, `resp_rdata` 0. Store funct3 3'b011 → `resp_err` 1 and `dmem_wr_en` never high.
- `resp_ready` held low for 5 cycles after a load → `resp_valid` and data stable for those cycles; `req_ready` stays 0 until the handshake.
- `rst_n` pulled low in ACC1 of a crossing store → no write on that edge; next cycle is IDLE with all outputs at their reset values.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the load/store path: memory size, funct3
// width codes and the LSU state encoding.
package rv32_pkg;

  localparam int unsigned DMEM_SIZE = 1024;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1,
    S_RESP
  } lsu_state_e;

  // Access size in bytes from funct3[1:0]; the reserved code maps to 4
  // and is rejected separately as illegal.
  function automatic logic [2:0] f3_size(input logic [1:0] w);
    case (w)
      2'b00:   f3_size = 3'd1;
      2'b01:   f3_size = 3'd2;
      default: f3_size = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment shared by both access phases: byte-lane
// mask, write-data shift, word-crossing detect and load extract/extend.
module lsu_align
  import rv32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic        phase1,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [31:0] bit_mask,
  output logic [31:0] wr_data,
  output logic [31:0] ld_data,
  output logic        crosses
);

  logic [2:0]       sz;
  logic [3:0][7:0]  m;
  logic [4:0]       sh_lo;
  logic [5:0]       sh_hi;
  logic [63:0]      raw;
  logic [31:0]      win;
  logic             sgn;

  // Phase 0 shifts lanes up by the offset; phase 1 carries the bytes that
  // spilled past the word boundary down into the next word.
  always_comb begin
    sz = f3_size(funct3[1:0]);
    for (int b = 0; b < 4; b++)
      m[b] = (3'(b) < sz) ? 8'hFF : 8'h00;
    crosses = ({2'b00, off} + {1'b0, sz}) > 4'd4;
    sh_lo   = {off, 3'b000};
    sh_hi   = 6'd32 - {1'b0, off, 3'b000};
    if (phase1) begin
      bit_mask = m >> sh_hi;
      wr_data  = wdata >> sh_hi;
    end else begin
      bit_mask = m << sh_lo;
      wr_data  = wdata << sh_lo;
    end
    raw = {hi, lo} >> sh_lo;
    win = raw[31:0];
    sgn = ~funct3[2];
    case (funct3[1:0])
      2'b00:   ld_data = {{24{sgn & win[7]}},  win[7:0]};
      2'b01:   ld_data = {{16{sgn & win[15]}}, win[15:0]};
      default: ld_data = win;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding request, split into one or two word
// accesses on dmem, with a registered response held until accepted.
module lsu
  import rv32_pkg::*;
#(
  parameter int unsigned DMEM_SIZE = rv32_pkg::DMEM_SIZE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dmem_wr_en,
  output logic [31:0] dmem_bit_wr_en,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wr_data,
  input  logic [31:0] dmem_rd_data
);

  lsu_state_e  state_q, state_d;
  logic        st_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, lo_q, rdata_q;
  logic        err_q;

  logic        phase1, crosses, err_c, illegal;
  logic [2:0]  sz_c;
  logic [31:0] al_mask, al_wdata, al_ld, lo_in, hi_in, word_addr;

  // Errors are judged on the registered request; the bound check is done
  // in 33 bits so addresses near 2^32 cannot wrap into range.
  always_comb begin
    sz_c    = f3_size(f3_q[1:0]);
    illegal = st_q ? (f3_q > F3_W)
                   : (f3_q == 3'b011 || f3_q == 3'b110 || f3_q == 3'b111);
    err_c   = illegal ||
              (({1'b0, addr_q} + {30'b0, sz_c}) > 33'(DMEM_SIZE));
    word_addr = {addr_q[31:2], 2'b00};
    // In ACC1 the live read is the upper word; a single access has hi = 0.
    lo_in = phase1 ? lo_q : dmem_rd_data;
    hi_in = phase1 ? dmem_rd_data : 32'h0;
  end

  lsu_align u_align (
    .funct3   (f3_q),
    .off      (addr_q[1:0]),
    .phase1   (phase1),
    .wdata    (wdata_q),
    .lo       (lo_in),
    .hi       (hi_in),
    .bit_mask (al_mask),
    .wr_data  (al_wdata),
    .ld_data  (al_ld),
    .crosses  (crosses)
  );

  // Next state and dmem/handshake outputs; write strobe is gated by rst_n
  // so a reset edge never commits a write.
  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    phase1         = 1'b0;
    dmem_wr_en     = 1'b0;
    dmem_addr      = 32'h0;
    dmem_bit_wr_en = 32'h0;
    dmem_wr_data   = 32'h0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_ACC0;
      end
      S_ACC0: begin
        dmem_addr      = word_addr;
        dmem_bit_wr_en = al_mask;
        dmem_wr_data   = al_wdata;
        dmem_wr_en     = st_q & ~err_c & rst_n;
        state_d        = (!err_c && crosses) ? S_ACC1 : S_RESP;
      end
      S_ACC1: begin
        phase1         = 1'b1;
        dmem_addr      = word_addr + 32'd4;
        dmem_bit_wr_en = al_mask;
        dmem_wr_data   = al_wdata;
        dmem_wr_en     = st_q & rst_n;
        state_d        = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, request capture, low-word capture and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      st_q    <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      lo_q    <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (req_valid) begin
          st_q    <= req_store;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
        end
        S_ACC0: begin
          lo_q <= dmem_rd_data;
          if (state_d == S_RESP) begin
            rdata_q <= (err_c || st_q) ? 32'h0 : al_ld;
            err_q   <= err_c;
          end
        end
        S_ACC1: begin
          rdata_q <= st_q ? 32'h0 : al_ld;
          err_q   <= 1'b0;
        end
        S_RESP: if (resp_ready) begin
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
